// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and single-cycle memory write port of the
// instruction/data memory loader.
//   master : the loader (consumes bytes, drives the memory write port)
//   slave  : the environment (byte source and memory)
interface imem_loader_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 14
);
  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     in_ready;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: fills the instruction/data memory from a framed little-endian
// byte stream (4-byte word count N, then N little-endian words) and holds the
// CPU in reset via busy_o until the image is complete.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing checksum
// byte C such that (sum of payload bytes + C) mod 256 == 0.
module imem_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 14,
  parameter int DEPTH         = 16383
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  imem_loader_if.master       bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_SUM, S_DONE, S_ERR
  } state_t;

  state_t                   state_q;
  logic [1:0]               byte_cnt_q;
  logic [23:0]              shift_q;
  logic [31:0]              n_q;
  logic [ADDRESS_WIDTH-1:0] word_cnt_q;
  logic                     in_ready_q;
  logic                     mem_we_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0]    mem_wdata_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]               sum_q;
  logic [7:0]               sum_d;
`endif

  logic                     xfer;
  logic [31:0]              word_d;
  logic                     last_word;

  // The incoming byte completes the word whose first three bytes sit in shift_q.
  assign xfer      = bus.in_valid && in_ready_q;
  assign word_d    = {bus.in_data, shift_q};
  assign last_word = (32'(word_cnt_q) == (n_q - 32'd1));
`ifdef LOADER_CHECKSUM_EN
  assign sum_d     = sum_q + bus.in_data;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

  // Load FSM with all outputs registered; mem_we is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      n_q         <= '0;
      word_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state_q    <= S_HDR;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
          end
        end
        S_HDR: begin
          if (xfer) begin
            shift_q    <= {bus.in_data, shift_q[23:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              n_q <= word_d;
              if (word_d > 32'(DEPTH)) begin
                state_q    <= S_ERR;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
              end else if (word_d == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                state_q    <= S_SUM;
`else
                state_q    <= S_DONE;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
`endif
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            shift_q    <= {bus.in_data, shift_q[23:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
            if (byte_cnt_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_cnt_q;
              mem_wdata_q <= word_d;
              word_cnt_q  <= word_cnt_q + 1'b1;
              if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                state_q    <= S_SUM;
`else
                state_q    <= S_DONE;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
`endif
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_SUM: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (sum_d == 8'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader. Writes are captured from
// the memory port and compared with hand-computed words.
module tb_imem_loader;

  logic clk;
  logic rst_n;
  logic start_i;
  logic busy_o;
  logic done_o;
  logic err_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [13:0] wa[$];
  logic [31:0] wd[$];

  logic [7:0] nom[12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                         8'h78, 8'h56, 8'h34, 8'h12,
                         8'hEF, 8'hBE, 8'hAD, 8'hDE};

  imem_loader_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(14)) bus ();

  imem_loader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(14), .DEPTH(16383)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .bus     (bus.master),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every memory write mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: in_ready stayed %b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start(input string tag);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check({tag, "_busy"},  busy_o, 1'b1);
    check({tag, "_ready"}, bus.in_ready, 1'b1);
    check({tag, "_done"},  done_o, 1'b0);
    check({tag, "_err"},   err_o, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, bus.in_ready, 1'b0);
    check({tag, "_we"},    bus.mem_we, 1'b0);
    check({tag, "_addr"},  32'(bus.mem_addr), 32'd0);
    check({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_busy"},  busy_o, 1'b0);
    check({tag, "_done"},  done_o, 1'b0);
    check({tag, "_err"},   err_o, 1'b0);
  endtask

  task automatic run_nominal(input string tag, input bit gaps);
    int base;
    base = wa.size();
    do_start({tag, "_start"});
    for (int i = 0; i < 12; i++) begin
      if (gaps) idle_cycles($urandom_range(0, 3));
      send_byte(nom[i]);
    end
`ifdef LOADER_CHECKSUM_EN
    check({tag, "_sum_busy"}, busy_o, 1'b1);
    check({tag, "_sum_we"},   bus.mem_we, 1'b1);
    // 0x78+0x56+0x34+0x12+0xEF+0xBE+0xAD+0xDE = 0x44C -> C = 0xB4
    send_byte(8'hB4);
`else
    check({tag, "_last_we"},    bus.mem_we, 1'b1);
    check({tag, "_last_addr"},  32'(bus.mem_addr), 32'd1);
    check({tag, "_last_wdata"}, bus.mem_wdata, 32'hDEADBEEF);
`endif
    check({tag, "_done"},  done_o, 1'b1);
    check({tag, "_busy"},  busy_o, 1'b0);
    check({tag, "_ready"}, bus.in_ready, 1'b0);
    check({tag, "_err"},   err_o, 1'b0);
    idle_cycles(1);
    check({tag, "_we_off"},     bus.mem_we, 1'b0);
    check({tag, "_addr_hold"},  32'(bus.mem_addr), 32'd1);
    check({tag, "_wdata_hold"}, bus.mem_wdata, 32'hDEADBEEF);
    check({tag, "_nwr"}, 32'(wa.size() - base), 32'd2);
    if (wa.size() >= base + 2) begin
      check({tag, "_a0"}, 32'(wa[base]),     32'd0);
      check({tag, "_d0"}, wd[base],          32'h12345678);
      check({tag, "_a1"}, 32'(wa[base + 1]), 32'd1);
      check({tag, "_d1"}, wd[base + 1],      32'hDEADBEEF);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n        = 1'b0;
    start_i      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset values.
    idle_cycles(3);
    check_zero_outputs("rst");
    rst_n = 1'b1;
    idle_cycles(2);
    check("idle_ready", bus.in_ready, 1'b0);
    check("idle_busy",  busy_o, 1'b0);

    // Nominal frame, back-to-back bytes.
    run_nominal("nom", 1'b0);

    // Oversize header N = 16384.
    base = wa.size();
    do_start("ovr_start");
    send_byte(8'h00); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
    check("ovr_err",   err_o, 1'b1);
    check("ovr_done",  done_o, 1'b0);
    check("ovr_busy",  busy_o, 1'b0);
    check("ovr_ready", bus.in_ready, 1'b0);
    idle_cycles(2);
    check("ovr_nwr", 32'(wa.size() - base), 32'd0);
    do_start("ovr_restart");

    // Empty frame N = 0 (already in HDR after the restart).
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    check("empty_sum_busy", busy_o, 1'b1);
    send_byte(8'h00);
`endif
    check("empty_done",  done_o, 1'b1);
    check("empty_busy",  busy_o, 1'b0);
    check("empty_ready", bus.in_ready, 1'b0);
    idle_cycles(2);
    check("empty_nwr", 32'(wa.size() - base), 32'd0);

    // Nominal frame again with random in_valid gaps.
    run_nominal("gap", 1'b1);

    // Abort: reset after 5 payload bytes, while bytes keep arriving.
    base = wa.size();
    do_start("abt_start");
    for (int i = 0; i < 9; i++) send_byte(nom[i]);
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hBE;
    #1;
    check_zero_outputs("abt");
    idle_cycles(3);
    check("abt_hold_we",   bus.mem_we, 1'b0);
    check("abt_hold_busy", busy_o, 1'b0);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    idle_cycles(2);
    check("abt_idle_ready", bus.in_ready, 1'b0);
    check("abt_idle_busy",  busy_o, 1'b0);
    check("abt_nwr", 32'(wa.size() - base), 32'd1);
    if (wa.size() >= base + 1) begin
      check("abt_a0", 32'(wa[base]), 32'd0);
      check("abt_d0", wd[base], 32'h12345678);
    end
    do_start("abt_restart");
    // Finish a clean empty frame so the loader ends idle-like.
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    check("abt_empty_done", done_o, 1'b1);

`ifdef LOADER_CHECKSUM_EN
    // Checksum pass: payload 0x00000001, C = 0xFF.
    base = wa.size();
    do_start("cs_ok_start");
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("cs_ok_we",   bus.mem_we, 1'b1);
    send_byte(8'hFF);
    check("cs_ok_done", done_o, 1'b1);
    check("cs_ok_err",  err_o, 1'b0);
    idle_cycles(1);
    check("cs_ok_nwr", 32'(wa.size() - base), 32'd1);
    if (wa.size() >= base + 1) begin
      check("cs_ok_a0", 32'(wa[base]), 32'd0);
      check("cs_ok_d0", wd[base], 32'h00000001);
    end

    // Checksum fail: same frame, C = 0x00.
    base = wa.size();
    do_start("cs_bad_start");
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00);
    check("cs_bad_err",  err_o, 1'b1);
    check("cs_bad_done", done_o, 1'b0);
    check("cs_bad_busy", busy_o, 1'b0);
    idle_cycles(1);
    check("cs_bad_nwr", 32'(wa.size() - base), 32'd1);
    if (wa.size() >= base + 1) begin
      check("cs_bad_d0", wd[base], 32'h00000001);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
